trigger_seq: RTL and testbench
==============================

// Module: trigger_seq
// PURPOSE
//  Parametrised logic-analyser trigger stage sitting between sample capture and the sample buffer.
//  TCN edge/level comparators produce an event vector from each sample and its predecessor.
//  A bus-writable state table, indexed by {events,state}, gives next state and a trigger flag.
//  Samples pass through one register stage tagged with events, state and trigger.
// PARAMETERS
//  SDW  32  sample data width
//  TCN  4   number of comparators (= event width)
//  TSW  4   state width; table depth 2**(TCN+TSW)
//  BAW  9   bus address width; must be >= 1+max(TCN+TSW, clog2(TCN)+3)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-high
//  arm         in   1       1: sequencer runs; 0: state forced 0, trigger suppressed, done cleared
//  bus_wen     in   1       config write strobe
//  bus_adr     in   BAW     config write address
//  bus_wdata   in   SDW     config write data
//  sti_tready  out  1       input stream ready
//  sti_tvalid  in   1       input stream valid
//  sti_tdata   in   SDW     input sample
//  sto_tready  in   1       output stream ready
//  sto_tvalid  out  1       output stream valid
//  sto_tdata   out  SDW     registered sample
//  sto_tevent  out  TCN     comparator events for that sample
//  sto_tstate  out  TSW     state after that sample
//  sto_ttrig   out  1       trigger flag of table entry used
//  trg_done    out  1       sticky: trigger seen since arm rose
// BEHAVIOUR
//  Reset: sto_tvalid/tdata/tevent/tstate/ttrig=0, trg_done=0, state=0, prev sample=0, all masks/modes=0.
//  Table RAM is not reset.
//  Handshake: sti_tready = ~sto_tvalid | sto_tready; transfer = sti_tvalid & sti_tready.
//  Latency 1: sample accepted in cycle N appears on sto_* in N+1.
//  sto_* hold stable while sto_tvalid & ~sto_tready.
//  sto_tvalid clears after an output handshake with no new transfer.
//  Comparator k: m = (~p&~d&M00)|(~p&d&M01)|(p&~d&M10)|(p&d&M11); p = prev sample, d = sti_tdata.
//  event[k] = mode[k] ? |m : &m (all-zero masks -> event 0).
//  prev sample updates only on transfer.
//  Table read is combinational: {nxt,trg} = tbl[{event,state}]; entry = {trg (bit TSW), nxt (TSW-1:0)}.
//  On transfer with arm=1: state<=nxt, sto_ttrig<=trg, trg_done<=trg_done|trg.
//  On transfer with arm=0: state<=0, sto_ttrig<=0.
//  arm=0 also forces state=0 and trg_done=0 every cycle, independent of transfer.
//  No transfer: state unchanged.
//  Bus map, adr[BAW-1]=1: tbl[adr[TCN+TSW-1:0]] <= wdata[TSW:0].
//  Bus map, adr[BAW-1]=0: k = adr[BAW-2:3]; adr[2:0] selects 0:M00 1:M01 2:M10 3:M11 4:mode (wdata[0]).
//  Writes to 5..7 or k>=TCN are ignored.
//  Simultaneous write and lookup of the same table entry or mask: the lookup uses the old value.
//  The new value applies from the next transfer.
//  Reset mid-stream: outputs drop to reset values immediately; any in-flight sample is lost.
// TESTING
//  Rising edge bit0: comp0 M01=1, mode=OR; samples 0,1,1,0 -> sto_tevent[0] = 0,1,0,0.
//  Level AND: comp1 M11=M01=0xFF, mode=AND; sample 0xFF after 0xFF -> event1=1; 0xFE -> 0.
//  Two-stage sequence: tbl[{e0,s0}] = s1, tbl[{e1,s1}] = s2|trg; arm=1; e0 then e1 -> sto_ttrig=1 on the e1 sample, trg_done=1.
//  Backpressure: hold sto_tready=0 for 3 cycles -> sti_tready=0; outputs stable; prev sample and state unchanged; no sample lost.
//  arm low mid-sequence in state 1 -> state 0, trg_done 0, ttrig 0 on later samples.
//  Reset asserted while sto_tvalid=1 -> all outputs 0 the same cycle; first post-reset sample compares against prev=0.

Source files
------------

// File: rtl/trigger_seq.sv
// Logic-analyser trigger stage: edge/level comparators form an event vector that,
// together with the current state, indexes a bus-writable next-state/trigger table.
module trigger_seq #(
  parameter int unsigned SDW = 32,
  parameter int unsigned TCN = 4,
  parameter int unsigned TSW = 4,
  parameter int unsigned BAW = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm,
  input  logic           bus_wen,
  input  logic [BAW-1:0] bus_adr,
  input  logic [SDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [SDW-1:0] sto_tdata,
  output logic [TCN-1:0] sto_tevent,
  output logic [TSW-1:0] sto_tstate,
  output logic           sto_ttrig,
  output logic           trg_done
);

  localparam int unsigned TAW    = TCN + TSW;
  localparam int unsigned TDEPTH = 2**TAW;

  logic           xfer;
  logic [TCN-1:0] event_vec;

  logic [SDW-1:0] prev_q, prev_d;
  logic [TSW-1:0] state_q, state_d;
  logic           trg_done_q, trg_done_d;
  logic           sto_tvalid_q, sto_tvalid_d;
  logic [SDW-1:0] sto_tdata_q, sto_tdata_d;
  logic [TCN-1:0] sto_tevent_q, sto_tevent_d;
  logic [TSW-1:0] sto_tstate_q, sto_tstate_d;
  logic           sto_ttrig_q, sto_ttrig_d;

  logic [TSW:0]   tbl_mem [TDEPTH];
  logic [TSW:0]   tbl_rd;
  logic           tbl_wen;

  // Comparators: mask registers live beside the comparator that uses them.
  for (genvar gi = 0; gi < TCN; gi++) begin : g_cmp
    localparam logic [BAW-5:0] KIDX = (BAW-4)'(gi);

    logic [SDW-1:0] m00_q, m00_d, m01_q, m01_d, m10_q, m10_d, m11_q, m11_d;
    logic           mode_q, mode_d;
    logic           hit;
    logic [SDW-1:0] m;

    assign hit = bus_wen & ~bus_adr[BAW-1] & (bus_adr[BAW-2:3] == KIDX);

    always_comb begin
      m00_d  = m00_q;
      m01_d  = m01_q;
      m10_d  = m10_q;
      m11_d  = m11_q;
      mode_d = mode_q;
      if (hit) begin
        case (bus_adr[2:0])
          3'd0:    m00_d  = bus_wdata;
          3'd1:    m01_d  = bus_wdata;
          3'd2:    m10_d  = bus_wdata;
          3'd3:    m11_d  = bus_wdata;
          3'd4:    mode_d = bus_wdata[0];
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        m00_q  <= '0;
        m01_q  <= '0;
        m10_q  <= '0;
        m11_q  <= '0;
        mode_q <= 1'b0;
      end else begin
        m00_q  <= m00_d;
        m01_q  <= m01_d;
        m10_q  <= m10_d;
        m11_q  <= m11_d;
        mode_q <= mode_d;
      end
    end

    assign m = (~prev_q & ~sti_tdata & m00_q) | (~prev_q & sti_tdata & m01_q) |
               ( prev_q & ~sti_tdata & m10_q) | ( prev_q & sti_tdata & m11_q);
    assign event_vec[gi] = mode_q ? (|m) : (&m);
  end

  // State table: registered write, combinational read so a same-cycle write is seen next transfer.
  assign tbl_wen = bus_wen & bus_adr[BAW-1];

  always_ff @(posedge clk) begin
    if (tbl_wen) begin
      tbl_mem[bus_adr[TAW-1:0]] <= bus_wdata[TSW:0];
    end
  end

  assign tbl_rd = tbl_mem[{event_vec, state_q}];

  assign sti_tready = ~sto_tvalid_q | sto_tready;
  assign xfer       = sti_tvalid & sti_tready;

  always_comb begin
    prev_d       = prev_q;
    state_d      = state_q;
    trg_done_d   = trg_done_q;
    sto_tvalid_d = sto_tvalid_q;
    sto_tdata_d  = sto_tdata_q;
    sto_tevent_d = sto_tevent_q;
    sto_tstate_d = sto_tstate_q;
    sto_ttrig_d  = sto_ttrig_q;
    if (sto_tready) begin
      sto_tvalid_d = 1'b0;
    end
    if (xfer) begin
      prev_d       = sti_tdata;
      sto_tvalid_d = 1'b1;
      sto_tdata_d  = sti_tdata;
      sto_tevent_d = event_vec;
      if (arm) begin
        state_d     = tbl_rd[TSW-1:0];
        sto_ttrig_d = tbl_rd[TSW];
        trg_done_d  = trg_done_q | tbl_rd[TSW];
      end else begin
        state_d     = '0;
        sto_ttrig_d = 1'b0;
      end
      sto_tstate_d = state_d;
    end
    // Disarmed: sequencer held idle regardless of traffic.
    if (!arm) begin
      state_d    = '0;
      trg_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      state_q      <= '0;
      trg_done_q   <= 1'b0;
      sto_tvalid_q <= 1'b0;
      sto_tdata_q  <= '0;
      sto_tevent_q <= '0;
      sto_tstate_q <= '0;
      sto_ttrig_q  <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      state_q      <= state_d;
      trg_done_q   <= trg_done_d;
      sto_tvalid_q <= sto_tvalid_d;
      sto_tdata_q  <= sto_tdata_d;
      sto_tevent_q <= sto_tevent_d;
      sto_tstate_q <= sto_tstate_d;
      sto_ttrig_q  <= sto_ttrig_d;
    end
  end

  assign sto_tvalid = sto_tvalid_q;
  assign sto_tdata  = sto_tdata_q;
  assign sto_tevent = sto_tevent_q;
  assign sto_tstate = sto_tstate_q;
  assign sto_ttrig  = sto_ttrig_q;
  assign trg_done   = trg_done_q;

endmodule

// File: tb/tb_trigger_seq.sv
// Directed bench for trigger_seq: comparators, table sequencing, backpressure, arm and reset.
module tb_trigger_seq;

  localparam int SDW = 32;
  localparam int TCN = 4;
  localparam int TSW = 4;
  localparam int BAW = 9;

  logic           clk = 1'b0;
  logic           rst;
  logic           arm;
  logic           bus_wen;
  logic [BAW-1:0] bus_adr;
  logic [SDW-1:0] bus_wdata;
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic [SDW-1:0] sto_tdata;
  logic [TCN-1:0] sto_tevent;
  logic [TSW-1:0] sto_tstate;
  logic           sto_ttrig;
  logic           trg_done;

  int n_checks = 0;
  int n_errors = 0;

  trigger_seq #(.SDW(SDW), .TCN(TCN), .TSW(TSW), .BAW(BAW)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .bus_wen    (bus_wen),
    .bus_adr    (bus_adr),
    .bus_wdata  (bus_wdata),
    .sti_tready (sti_tready),
    .sti_tvalid (sti_tvalid),
    .sti_tdata  (sti_tdata),
    .sto_tready (sto_tready),
    .sto_tvalid (sto_tvalid),
    .sto_tdata  (sto_tdata),
    .sto_tevent (sto_tevent),
    .sto_tstate (sto_tstate),
    .sto_ttrig  (sto_ttrig),
    .trg_done   (trg_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int adr, input logic [SDW-1:0] data);
    bus_wen   = 1'b1;
    bus_adr   = BAW'(adr);
    bus_wdata = data;
    tick();
    bus_wen   = 1'b0;
  endtask

  task automatic send(input logic [SDW-1:0] d);
    sti_tvalid = 1'b1;
    sti_tdata  = d;
    tick();
    sti_tvalid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [SDW-1:0] d, input logic [TCN-1:0] ev,
                            input logic [TSW-1:0] st, input logic trg, input logic done);
    $display("%s: data=0x%08h event=%b state=%0d trig=%b done=%b", tag, sto_tdata, sto_tevent,
             sto_tstate, sto_ttrig, trg_done);
    check_eq({tag, "_vld"},   64'(sto_tvalid), 64'(1'b1));
    check_eq({tag, "_data"},  64'(sto_tdata),  64'(d));
    check_eq({tag, "_event"}, 64'(sto_tevent), 64'(ev));
    check_eq({tag, "_state"}, 64'(sto_tstate), 64'(st));
    check_eq({tag, "_trig"},  64'(sto_ttrig),  64'(trg));
    check_eq({tag, "_done"},  64'(trg_done),   64'(done));
  endtask

  task automatic expect_idle_zero(input string tag);
    check_eq({tag, "_vld"},   64'(sto_tvalid), 64'(0));
    check_eq({tag, "_data"},  64'(sto_tdata),  64'(0));
    check_eq({tag, "_event"}, 64'(sto_tevent), 64'(0));
    check_eq({tag, "_state"}, 64'(sto_tstate), 64'(0));
    check_eq({tag, "_trig"},  64'(sto_ttrig),  64'(0));
    check_eq({tag, "_done"},  64'(trg_done),   64'(0));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    arm        = 1'b0;
    bus_wen    = 1'b0;
    bus_adr    = '0;
    bus_wdata  = '0;
    sti_tvalid = 1'b0;
    sti_tdata  = '0;
    sto_tready = 1'b1;
    repeat (2) tick();

    // Reset state
    expect_idle_zero("reset");
    check_eq("reset_sti_tready", 64'(sti_tready), 64'(1));
    rst = 1'b0;
    tick();

    // Table RAM is not reset: clear every entry so unwritten lookups go to state 0, no trigger.
    for (int i = 0; i < 256; i++) bus_wr(256 + i, '0);

    // Rising edge on bit 0: comp0 M01=1, OR mode.
    bus_wr(1, 32'h1);
    bus_wr(4, 32'h1);
    send(32'h0); expect_out("rise_s0", 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    send(32'h1); expect_out("rise_s1", 32'h1, 4'b0001, 4'd0, 1'b0, 1'b0);
    send(32'h1); expect_out("rise_s2", 32'h1, 4'b0000, 4'd0, 1'b0, 1'b0);
    send(32'h0); expect_out("rise_s3", 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);

    // Level AND: comp1 M01=M11=all ones -> every bit currently high.
    bus_wr(9,  32'hFFFF_FFFF);
    bus_wr(11, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF); expect_out("lvl_a", 32'hFFFF_FFFF, 4'b0011, 4'd0, 1'b0, 1'b0);
    send(32'hFFFF_FFFF); expect_out("lvl_b", 32'hFFFF_FFFF, 4'b0010, 4'd0, 1'b0, 1'b0);
    send(32'hFFFF_FFFE); expect_out("lvl_c", 32'hFFFF_FFFE, 4'b0000, 4'd0, 1'b0, 1'b0);

    // Two-stage sequence: {e=0001,s=0} -> s1 ; {e=0010,s=1} -> s2 + trigger.
    bus_wr(256 + 16, 32'h01);
    bus_wr(256 + 33, 32'h12);
    arm = 1'b1;
    tick();
    check_eq("arm_done0", 64'(trg_done), 64'(0));
    send(32'h0000_0001); expect_out("seq_e0",  32'h0000_0001, 4'b0001, 4'd1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF); expect_out("seq_e1",  32'hFFFF_FFFF, 4'b0010, 4'd2, 1'b1, 1'b1);
    send(32'hFFFF_FFFF); expect_out("seq_aft", 32'hFFFF_FFFF, 4'b0010, 4'd0, 1'b0, 1'b1);

    // Output drains after a handshake with no new transfer.
    tick();
    check_eq("drain_vld", 64'(sto_tvalid), 64'(0));

    // Backpressure: A accepted, B stalled three cycles, then B must arrive intact.
    sto_tready = 1'b0;
    send(32'hFFFF_FFFE);
    sti_tvalid = 1'b1;
    sti_tdata  = 32'hFFFF_FFFF;
    #1;
    check_eq("bp_ready0", 64'(sti_tready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("bp_hold%0d: ready=%b data=0x%08h", i, sti_tready, sto_tdata);
      check_eq("bp_ready", 64'(sti_tready), 64'(0));
      check_eq("bp_vld",   64'(sto_tvalid), 64'(1));
      check_eq("bp_data",  64'(sto_tdata),  64'(32'hFFFF_FFFE));
      check_eq("bp_event", 64'(sto_tevent), 64'(0));
      check_eq("bp_state", 64'(sto_tstate), 64'(0));
    end
    sto_tready = 1'b1;
    #1;
    check_eq("bp_ready1", 64'(sti_tready), 64'(1));
    tick();
    sti_tvalid = 1'b0;
    expect_out("bp_b", 32'hFFFF_FFFF, 4'b0011, 4'd0, 1'b0, 1'b1);
    tick();
    check_eq("bp_drain_vld", 64'(sto_tvalid), 64'(0));

    // Arm dropped while in state 1.
    send(32'hFFFF_FFFE); expect_out("arm_s0", 32'hFFFF_FFFE, 4'b0000, 4'd0, 1'b0, 1'b1);
    send(32'h0000_0001); expect_out("arm_s1", 32'h0000_0001, 4'b0001, 4'd1, 1'b0, 1'b1);
    arm = 1'b0;
    tick();
    check_eq("disarm_done", 64'(trg_done), 64'(0));
    send(32'hFFFF_FFFF); expect_out("disarm_smp", 32'hFFFF_FFFF, 4'b0010, 4'd0, 1'b0, 1'b0);
    arm = 1'b1;
    send(32'hFFFF_FFFF); expect_out("rearm_smp",  32'hFFFF_FFFF, 4'b0010, 4'd0, 1'b0, 1'b0);

    // Writes to comparator k=4 and to select 6 must be ignored.
    bus_wr(34, 32'hFFFF_FFFF);
    bus_wr(14, 32'hFFFF_FFFF);
    send(32'h0); expect_out("ign_wr", 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);

    // Same-cycle table write and lookup: lookup sees the old entry.
    sti_tvalid = 1'b1;
    sti_tdata  = 32'h1;
    bus_wen    = 1'b1;
    bus_adr    = BAW'(256 + 16);
    bus_wdata  = 32'h13;
    tick();
    sti_tvalid = 1'b0;
    bus_wen    = 1'b0;
    expect_out("wr_old", 32'h1, 4'b0001, 4'd1, 1'b0, 1'b0);
    send(32'h0); expect_out("wr_mid", 32'h0, 4'b0000, 4'd0, 1'b0, 1'b0);
    send(32'h1); expect_out("wr_new", 32'h1, 4'b0001, 4'd3, 1'b1, 1'b1);

    // Reset while a sample is on the output and another is offered.
    sti_tvalid = 1'b1;
    sti_tdata  = 32'hA5A5_A5A5;
    sto_tready = 1'b0;
    rst        = 1'b1;
    #1;
    expect_idle_zero("rst_mid");
    sti_tvalid = 1'b0;
    sto_tready = 1'b1;
    #2;
    rst = 1'b0;
    tick();
    check_eq("rst_after_vld", 64'(sto_tvalid), 64'(0));
    bus_wr(1, 32'h1);
    bus_wr(4, 32'h1);
    send(32'h1); expect_out("post_rst", 32'h1, 4'b0001, 4'd3, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
